// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and stream-format constants for the program loader
package loader_pkg;
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR} state_t;
  localparam int HDR_LEN = 2;
  localparam int CSUM_W = 8;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: assembles four consecutive bytes into a little-endian 32-bit word
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [1:0] lane;
  logic [23:0] sr;
  assign word_valid = en && lane == 2'd3;
  assign word = {data, sr};
  // lane counter and shift register holding the three lower bytes of the word
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lane <= '0;
      sr <= '0;
    end else if (clear) begin
      lane <= '0;
      sr <= '0;
    end else if (en) begin
      lane <= lane + 2'd1;
      sr <= {data, sr[23:8]};
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a checksummed byte-stream image into instruction memory, holding the core in reset until done
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_hold
);
  localparam int MAX_WORDS = (1 << (ADDR_WIDTH - 2)) - BASE_ADDR / 4;
  localparam int WC_W = 8 * HDR_LEN;
  state_t state, next;
  logic [WC_W-1:0] wc, n_hdr;
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [CSUM_W-1:0] csum, csum_next;
  logic accept, word_valid, last_word;
  logic [31:0] word;
  assign in_ready = state inside {HDR0, HDR1, DATA, CSUM};
  assign busy = in_ready;
  assign done = state == DONE;
  assign error = state == ERR;
  assign cpu_hold = !done;
  assign accept = in_valid && in_ready;
  assign n_hdr = {in_data, wc[7:0]};
  assign csum_next = csum + in_data;
  assign last_word = 32'(word_idx) + 1 == 32'(wc);
  byte_packer u_packer (
    .clk(clk),
    .rst(rst),
    .clear(start),
    .en(accept && state == DATA),
    .data(in_data),
    .word_valid(word_valid),
    .word(word)
  );
  // next-state: stream parsing, with start overriding everything as a restart/abort
  always_comb begin
    next = state;
    case (state)
      HDR0: next = accept ? HDR1 : HDR0;
      HDR1: next = !accept ? HDR1 : 32'(n_hdr) > MAX_WORDS ? ERR : n_hdr == '0 ? CSUM : DATA;
      DATA: next = word_valid && last_word ? CSUM : DATA;
      CSUM: next = !accept ? CSUM : csum_next == '0 ? DONE : ERR;
      default: next = state;
    endcase
    if (start) next = HDR0;
  end
  // state, counters, checksum and registered write port; start discards the byte on its edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      wc <= '0;
      word_idx <= '0;
      csum <= '0;
      mem_wen <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      state <= next;
      mem_wen <= word_valid && !start;
      if (start) begin
        wc <= '0;
        word_idx <= '0;
        csum <= '0;
      end else begin
        if (accept) csum <= csum_next;
        if (accept && state == HDR0) wc[7:0] <= in_data;
        if (accept && state == HDR1) wc[WC_W-1:8] <= in_data;
        if (word_valid) begin
          word_idx <= word_idx + 1'b1;
          mem_addr <= ADDR_WIDTH'(BASE_ADDR) + {word_idx, 2'b00};
          mem_wdata <= DATA_WIDTH'(word);
        end
      end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized stream tests of imem_loader against a stream-level reference model
module tb_imem_loader;
  logic clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready0, mem_wen0, busy0, done0, error0, cpu_hold0;
  logic in_ready1, mem_wen1, busy1, done1, error1, cpu_hold1;
  logic [15:0] mem_addr0, mem_addr1;
  logic [31:0] mem_wdata0, mem_wdata1;
  logic [47:0] wq0[$], wq1[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .mem_wen(mem_wen0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .busy(busy0), .done(done0), .error(error0), .cpu_hold(cpu_hold0));

  imem_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .BASE_ADDR(32'h100)) dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .mem_wen(mem_wen1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .busy(busy1), .done(done1), .error(error1), .cpu_hold(cpu_hold1));

  always @(negedge clk) begin
    if (mem_wen0) wq0.push_back({mem_addr0, mem_wdata0});
    if (mem_wen1) wq1.push_back({mem_addr1, mem_wdata1});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic send(input logic [7:0] b, input int maxgap);
    int t = 0;
    repeat ($urandom_range(maxgap, 0)) @(negedge clk);
    in_valid = 1;
    in_data = b;
    while (!in_ready0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready0) check("ready_timeout", 0, 1);
    else @(posedge clk);
    @(negedge clk) in_valid = 0;
  endtask

  task automatic verify(input string tag, input logic [7:0] s[$], input int base,
                        input logic [47:0] wq[$], input logic d, input logic e,
                        input logic h, input logic b, input logic r);
    int n, nw;
    bit over, ok;
    logic [7:0] sum = 0;
    logic [31:0] w;
    n = int'(s[0]) + 256 * int'(s[1]);
    over = n > 16384 - base / 4;
    nw = over ? 0 : n;
    foreach (s[i]) sum += s[i];
    ok = !over && sum == 0;
    check({tag, "_nwr"}, 64'(wq.size()), 64'(nw));
    for (int i = 0; i < nw && i < wq.size(); i++) begin
      w = {s[5 + 4 * i], s[4 + 4 * i], s[3 + 4 * i], s[2 + 4 * i]};
      check({tag, "_wr"}, 64'(wq[i]), {16'h0, 16'(base + 4 * i), w});
    end
    check({tag, "_done"}, 64'(d), 64'(ok));
    check({tag, "_error"}, 64'(e), 64'(!ok));
    check({tag, "_hold"}, 64'(h), 64'(!ok));
    check({tag, "_busy"}, 64'(b), 0);
    check({tag, "_ready"}, 64'(r), 0);
  endtask

  task automatic run(input string tag, input logic [7:0] s[$], input int maxgap);
    wq0.delete();
    wq1.delete();
    pulse_start();
    foreach (s[i]) send(s[i], maxgap);
    repeat (3) @(negedge clk);
    verify({tag, "0"}, s, 0, wq0, done0, error0, cpu_hold0, busy0, in_ready0);
    verify({tag, "1"}, s, 32'h100, wq1, done1, error1, cpu_hold1, busy1, in_ready1);
  endtask

  initial begin
    logic [7:0] t2[$], s[$];
    logic [7:0] sum;
    int n;
    #1000000;
    $display("FAIL global_timeout got 0 exp 1");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] t2[$], t3[$], s[$];
    logic [7:0] sum;
    int n;
    t2 = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hB2};
    repeat (3) @(negedge clk);
    check("rst_hold", cpu_hold0, 1);
    check("rst_ready", in_ready0, 0);
    check("rst_wen", mem_wen0, 0);
    check("rst_done", done0, 0);
    check("rst_error", error0, 0);
    check("rst_addr", mem_addr0, 0);
    check("rst_wdata", mem_wdata0, 0);
    rst = 0;
    in_valid = 1;
    repeat (4) @(negedge clk);
    check("idle_ready", in_ready0, 0);
    check("idle_busy", busy0, 0);
    check("idle_wen", mem_wen0, 0);
    in_valid = 0;

    run("t2", t2, 0);
    t3 = t2;
    t3[10] = 8'hB3;
    run("t3", t3, 0);
    pulse_start();
    check("restart_err_clr", error0, 0);
    check("restart_busy", busy0, 1);
    run("t4", '{8'h00, 8'h00, 8'h00}, 0);
    run("t5", t2, 5);

    wq0.delete();
    wq1.delete();
    pulse_start();
    for (int i = 0; i < 9; i++) send(t2[i], 0);
    repeat (2) @(negedge clk);
    check("abort_nwr", wq0.size(), 1);
    if (wq0.size() > 0) check("abort_wr", wq0[0], {16'h0000, 32'h12345678});
    check("abort_busy", busy0, 1);
    pulse_start();
    repeat (6) @(negedge clk);
    check("abort_nwr_after", wq0.size(), 1);
    check("abort_hold", cpu_hold0, 1);
    run("t6a", t2, 2);

    wq0.delete();
    pulse_start();
    send(8'h01, 0);
    send(8'h40, 0);
    check("over_error_now", error0, 1);
    check("over_ready_now", in_ready0, 0);
    repeat (2) @(negedge clk);
    verify("t6b", '{8'h01, 8'h40}, 0, wq0, done0, error0, cpu_hold0, busy0, in_ready0);

    pulse_start();
    for (int i = 0; i < 5; i++) send(t2[i], 0);
    #2 rst = 1;
    #1;
    check("arst_busy", busy0, 0);
    check("arst_hold", cpu_hold0, 1);
    check("arst_ready", in_ready0, 0);
    check("arst_wen", mem_wen0, 0);
    @(negedge clk) rst = 0;

    for (int k = 0; k < 10; k++) begin
      n = $urandom_range(5, 0);
      s = '{8'(n), 8'h00};
      for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
      sum = 0;
      foreach (s[i]) sum += s[i];
      s.push_back(($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'(-sum));
      run("rnd", s, $urandom_range(5, 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
